// File: rtl/loader_ctrl.sv
// rtl/loader_ctrl.sv - CHR double-buffer upload sequencer with launch stretch and button sync
// Optional feature macro: LOADER_CTRL_WATCHDOG_EN (WAIT_LATCH watchdog, sticky timeout_err)
module loader_ctrl #(
  parameter int ADDR_BITS    = 15,
  parameter int PULSE_CYCLES = 8,
  parameter int TIMEOUT      = 1 << 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [7:0]           wr_data,
  input  logic                 wr_last,
  output logic                 mem_req,
  input  logic                 mem_ack,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic                 latch_toggle,
  output logic                 buffer_num,
  input  logic                 prelaunch_req,
  input  logic                 launch_req,
  output logic                 prelaunch,
  output logic                 launch,
  input  logic [7:0]           buttons,
  output logic [7:0]           buttons_q,
  output logic                 buttons_chg,
  output logic                 busy,
  output logic [7:0]           frames_done,
  output logic                 timeout_err
);
  localparam int CW = ADDR_BITS - 1;
  localparam int PW = $clog2(PULSE_CYCLES + 1);

  if (PULSE_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
    $error("loader_ctrl: PULSE_CYCLES and TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_WAIT_LATCH} state_t;
  state_t state, state_n;

  logic [CW-1:0] cnt;
  logic          last_q;
  logic [2:0]    latch_sync;
  logic          latch_edge;
  logic          accept, ack, flip, abort, wd_expire;
  logic [PW-1:0] pre_cnt, lau_cnt;
  logic [7:0]    btn_s1, btn_s2, btn_s3;

  assign abort      = launch_req;
  assign latch_edge = latch_sync[1] ^ latch_sync[2];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next-state and handshake decode; a launch request overrides everything
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    ack      = 1'b0;
    flip     = 1'b0;
    wr_ready = (state == S_FILL);
    busy     = (state != S_IDLE);
    case (state)
      S_IDLE:  if (wr_valid) state_n = S_FILL;
      S_FILL:  if (wr_valid) begin
                 accept  = 1'b1;
                 state_n = S_WRITE;
               end
      S_WRITE: if (mem_ack) begin
                 ack = 1'b1;
                 // all-ones cnt is an implicit last so we never spill into the front buffer
                 if (last_q || (&cnt)) begin
                   flip    = 1'b1;
                   state_n = S_WAIT_LATCH;
                 end else begin
                   state_n = S_FILL;
                 end
               end
      S_WAIT_LATCH: if (latch_edge || wd_expire) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort) begin
      state_n = S_IDLE;
      accept  = 1'b0;
      ack     = 1'b0;
      flip    = 1'b0;
    end
  end

  // Write datapath, buffer flip and frame counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      last_q      <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      buffer_num  <= 1'b0;
      frames_done <= '0;
    end else begin
      if (state == S_IDLE) cnt <= '0;
      if (accept) begin
        mem_addr  <= {~buffer_num, cnt};
        mem_wdata <= wr_data;
        last_q    <= wr_last;
        mem_req   <= 1'b1;
      end
      if (ack) begin
        mem_req <= 1'b0;
        cnt     <= cnt + 1'b1;
      end
      if (abort) mem_req <= 1'b0;
      if (flip) begin
        buffer_num  <= ~buffer_num;
        frames_done <= frames_done + 8'd1;
      end
    end
  end

  // latch_toggle: two sync flops plus one for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) latch_sync <= '0;
    else          latch_sync <= {latch_sync[1:0], latch_toggle};
  end

`ifdef LOADER_CTRL_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;

  assign wd_expire = (state == S_WAIT_LATCH) && (wd_cnt == WW'(TIMEOUT - 1));

  // Watchdog counts cycles spent in WAIT_LATCH; timeout_err is sticky until reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != S_WAIT_LATCH) wd_cnt <= '0;
      else                       wd_cnt <= wd_cnt + 1'b1;
      if (wd_expire && !latch_edge && !abort) timeout_err <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Pulse stretchers so the slower m2 domain can sample the requests
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      lau_cnt <= '0;
    end else begin
      if (prelaunch_req)       pre_cnt <= PW'(PULSE_CYCLES);
      else if (pre_cnt != '0)  pre_cnt <= pre_cnt - 1'b1;
      if (launch_req)          lau_cnt <= PW'(PULSE_CYCLES);
      else if (lau_cnt != '0)  lau_cnt <= lau_cnt - 1'b1;
    end
  end

  assign prelaunch = (pre_cnt != '0);
  assign launch    = (lau_cnt != '0);

  // Button sync; update only after the synced value holds for two cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1      <= '0;
      btn_s2      <= '0;
      btn_s3      <= '0;
      buttons_q   <= '0;
      buttons_chg <= 1'b0;
    end else begin
      btn_s1      <= buttons;
      btn_s2      <= btn_s1;
      btn_s3      <= btn_s2;
      buttons_chg <= 1'b0;
      if ((btn_s2 == btn_s3) && (btn_s2 != buttons_q)) begin
        buttons_q   <= btn_s2;
        buttons_chg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_loader_ctrl.sv
// tb/tb_loader_ctrl.sv - randomized self-checking bench for loader_ctrl
`timescale 1ns/1ps
module tb_loader_ctrl;
  localparam int AB   = 15;
  localparam int HALF = 1 << (AB - 1);
  localparam int PC   = 8;
  localparam int TO   = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [7:0]    wr_data = '0;
  logic          wr_last = 1'b0;
  logic          mem_req;
  logic          mem_ack = 1'b0;
  logic [AB-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          latch_toggle = 1'b0;
  logic          buffer_num;
  logic          prelaunch_req = 1'b0;
  logic          launch_req = 1'b0;
  logic          prelaunch;
  logic          launch;
  logic [7:0]    buttons = '0;
  logic [7:0]    buttons_q;
  logic          buttons_chg;
  logic          busy;
  logic [7:0]    frames_done;
  logic          timeout_err;

  int errors = 0;
  int checks = 0;

  bit         auto_ack = 1'b1;
  int         max_dly = 0;
  int         ack_dly = 0;
  int         waitc = 0;
  logic [22:0] wr_log[$];
  logic [7:0]  frame_q[$];
  bit          m_buf;
  int          m_frames;

  loader_ctrl #(.ADDR_BITS(AB), .PULSE_CYCLES(PC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_last(wr_last), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .latch_toggle(latch_toggle),
    .buffer_num(buffer_num), .prelaunch_req(prelaunch_req), .launch_req(launch_req),
    .prelaunch(prelaunch), .launch(launch), .buttons(buttons), .buttons_q(buttons_q),
    .buttons_chg(buttons_chg), .busy(busy), .frames_done(frames_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // memory responder: acks after a random delay and logs each write
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack) begin
        if (!reset_n || mem_ack) begin
          mem_ack = 1'b0;
          waitc   = 0;
        end else if (mem_req) begin
          if (waitc >= ack_dly) begin
            mem_ack = 1'b1;
            wr_log.push_back({mem_addr, mem_wdata});
            waitc   = 0;
            ack_dly = $urandom_range(0, max_dly);
          end else begin
            waitc++;
          end
        end
      end
    end
  end

  task automatic set_dly(input int m);
    max_dly = m;
    ack_dly = $urandom_range(0, m);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; launch_req = 1'b0;
    prelaunch_req = 1'b0; latch_toggle = 1'b0; buttons = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wr_log.delete();
    m_buf = 1'b0;
    m_frames = 0;
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    int n = 0;
    wr_valid = 1'b1; wr_data = d; wr_last = l;
    while (!wr_ready && n < 64) begin @(negedge clk); n++; end
    checks++;
    if (!wr_ready) begin
      errors++;
      $display("FAIL send_beat_timeout wr_ready=%0b required=1", wr_ready);
    end
    @(negedge clk);
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit with_last, input int base);
    logic [7:0] b;
    frame_q.delete();
    wr_log.delete();
    for (int i = 0; i < len; i++) begin
      b = (base >= 0) ? 8'(base + i) : 8'($urandom);
      frame_q.push_back(b);
      send_beat(b, with_last && (i == len - 1));
    end
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done != 8'(target) && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (frames_done != 8'(target)) begin
      errors++;
      $display("FAIL wait_frames frames_done=%0d required=%0d", frames_done, target);
    end
  endtask

  // expected write list: byte i of a frame goes to {back buffer, i}, capped at one buffer
  task automatic check_log(input string name);
    int n = frame_q.size();
    logic [22:0] e;
    if (n > HALF) n = HALF;
    checks++;
    if (wr_log.size() != n) begin
      errors++;
      $display("FAIL %s_count writes=%0d required=%0d", name, wr_log.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        e = {~m_buf, 14'(i), frame_q[i]};
        if (wr_log[i] !== e) begin
          errors++;
          $display("FAIL %s_write[%0d] addr/data=%h/%h required=%h/%h", name, i,
                   wr_log[i][22:8], wr_log[i][7:0], e[22:8], e[7:0]);
          break;
        end
      end
    end
  endtask

  task automatic model_flip();
    m_buf = ~m_buf;
    m_frames = (m_frames + 1) % 256;
  endtask

  task automatic release_latch();
    int n = 0;
    latch_toggle = ~latch_toggle;
    while (busy && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (busy || n < 3 || n > 4) begin
      errors++;
      $display("FAIL latch_to_idle busy=%0b cycles=%0d required=0 within 3..4", busy, n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({wr_ready, mem_req, mem_addr, mem_wdata, buffer_num, frames_done, prelaunch, launch,
         buttons_q, buttons_chg, busy, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ready=%0b req=%0b addr=%h buf=%0b frames=%0d busy=%0b required=all 0",
               wr_ready, mem_req, mem_addr, buffer_num, frames_done, busy);
    end
    auto_ack = 1'b0;
    send_beat(8'h5A, 1'b1);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL req_held mem_req=%0b required=1", mem_req);
    end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_mid_write mem_req=%0b required=0", mem_req);
    end
    @(negedge clk);
    reset_n = 1'b1;
    auto_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle busy=%0b required=0", busy);
    end
  endtask

  task automatic test_full_frame();
    apply_reset();
    set_dly(0);
    send_frame(4, 1'b1, 8'hA0);
    checks++;
    if (buffer_num !== 1'b0) begin
      errors++; $display("FAIL flip_early buffer_num=%0b required=0", buffer_num);
    end
    @(negedge clk);
    check_log("full_frame");
    model_flip();
    checks++;
    if (buffer_num !== m_buf || frames_done !== 8'(m_frames) || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_flip buf=%0b frames=%0d busy=%0b required=%0b/%0d/1",
               buffer_num, frames_done, busy, m_buf, m_frames);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL wait_latch_hold busy=%0b required=1", busy);
    end
    release_latch();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int f = 0; f < 2; f++) begin
      set_dly($urandom_range(0, 2));
      send_frame(2, 1'b1, -1);
      wait_frames(m_frames + 1);
      check_log("back_to_back");
      model_flip();
      checks++;
      if (buffer_num !== m_buf) begin
        errors++; $display("FAIL b2b_buffer buffer_num=%0b required=%0b", buffer_num, m_buf);
      end
      release_latch();
    end
  endtask

  task automatic test_random_frames();
    apply_reset();
    for (int f = 0; f < 6; f++) begin
      set_dly($urandom_range(0, 3));
      send_frame($urandom_range(1, 12), 1'b1, -1);
      wait_frames(m_frames + 1);
      check_log("random_frame");
      model_flip();
      checks++;
      if (buffer_num !== m_buf || frames_done !== 8'(m_frames)) begin
        errors++;
        $display("FAIL random_flip buf=%0b frames=%0d required=%0b/%0d",
                 buffer_num, frames_done, m_buf, m_frames);
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
      release_latch();
    end
  endtask

  task automatic test_implicit_last();
    apply_reset();
    set_dly(0);
    send_frame(HALF, 1'b0, -1);
    wait_frames(1);
    repeat (4) @(negedge clk);
    check_log("implicit_last");
    checks++;
    if (wr_log.size() == 0 || wr_log[wr_log.size()-1][22:8] !== 15'h7FFF) begin
      errors++;
      $display("FAIL implicit_last_addr addr=%h required=7fff",
               (wr_log.size() == 0) ? 15'h0 : wr_log[wr_log.size()-1][22:8]);
    end
    model_flip();
    checks++;
    if (buffer_num !== m_buf || mem_req !== 1'b0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL implicit_flip buf=%0b req=%0b ready=%0b required=%0b/0/0",
               buffer_num, mem_req, wr_ready, m_buf);
    end
    release_latch();
  endtask

  task automatic test_latch_ignored();
    apply_reset();
    set_dly(1);
    frame_q.delete();
    wr_log.delete();
    frame_q.push_back(8'h3C);
    send_beat(8'h3C, 1'b0);
    latch_toggle = ~latch_toggle;
    repeat (6) @(negedge clk);
    frame_q.push_back(8'hC3);
    send_beat(8'hC3, 1'b1);
    wait_frames(1);
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL early_edge_consumed busy=%0b required=1", busy);
    end
    check_log("latch_ignored");
    model_flip();
    release_latch();
  endtask

  task automatic test_abort();
    int n;
    apply_reset();
    auto_ack = 1'b0;
    send_beat(8'h11, 1'b1);
    mem_ack = 1'b1;
    launch_req = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    launch_req = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || buffer_num !== 1'b0 || frames_done !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_state req=%0b buf=%0b frames=%0d busy=%0b required=0/0/0/0",
               mem_req, buffer_num, frames_done, busy);
    end
    n = 0;
    while (launch && n < 40) begin n++; @(negedge clk); end
    checks++;
    if (n != PC) begin
      errors++; $display("FAIL launch_width cycles=%0d required=%0d", n, PC);
    end
    launch_req = 1'b1;
    @(negedge clk);
    launch_req = 1'b0;
    n = 0;
    while (launch && n < 40) begin
      n++;
      if (n == 5) launch_req = 1'b1;
      @(negedge clk);
      launch_req = 1'b0;
    end
    checks++;
    if (n != 5 + PC) begin
      errors++; $display("FAIL launch_extend cycles=%0d required=%0d", n, 5 + PC);
    end
    prelaunch_req = 1'b1;
    @(negedge clk);
    prelaunch_req = 1'b0;
    n = 0;
    while (prelaunch && n < 40) begin
      n++;
      if (launch) n = n + 100;
      @(negedge clk);
    end
    checks++;
    if (n != PC) begin
      errors++; $display("FAIL prelaunch_width cycles=%0d required=%0d (launch quiet)", n, PC);
    end
    auto_ack = 1'b1;
    set_dly(1);
    send_frame(3, 1'b1, -1);
    wait_frames(1);
    check_log("after_abort");
    model_flip();
    release_latch();
  endtask

  task automatic test_buttons();
    int pulses, lat;
    bit saw_ff;
    logic [7:0] v, mq;
    apply_reset();
    buttons = 8'hFF;
    @(negedge clk);
    buttons = 8'h81;
    pulses = 0; lat = 0; saw_ff = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (buttons_chg) begin
        pulses++;
        if (lat == 0) lat = i + 1;
      end
      if (buttons_q == 8'hFF) saw_ff = 1'b1;
    end
    checks++;
    if (pulses != 1 || buttons_q !== 8'h81 || saw_ff) begin
      errors++;
      $display("FAIL buttons_glitch pulses=%0d q=%h saw_ff=%0b required=1/81/0", pulses, buttons_q, saw_ff);
    end
    checks++;
    if (lat < 3 || lat > 4) begin
      errors++; $display("FAIL buttons_latency cycles=%0d required=3..4", lat);
    end
    mq = 8'h81;
    for (int k = 0; k < 6; k++) begin
      v = (k == 2) ? mq : 8'($urandom);
      buttons = v;
      pulses = 0;
      repeat (8) begin
        @(negedge clk);
        if (buttons_chg) pulses++;
      end
      checks++;
      if (buttons_q !== v || pulses != ((v != mq) ? 1 : 0)) begin
        errors++;
        $display("FAIL buttons_random q=%h pulses=%0d required=%h/%0d", buttons_q, pulses, v, (v != mq) ? 1 : 0);
      end
      mq = v;
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    set_dly(0);
    for (int f = 0; f < 256; f++) begin
      send_frame(1, 1'b1, -1);
      wait_frames(m_frames + 1);
      model_flip();
      if (f == 254) begin
        checks++;
        if (frames_done !== 8'd255) begin
          errors++; $display("FAIL frames_255 frames=%0d required=255", frames_done);
        end
      end
      release_latch();
    end
    checks++;
    if (frames_done !== 8'd0 || buffer_num !== 1'b0) begin
      errors++;
      $display("FAIL frames_wrap frames=%0d buf=%0b required=0/0", frames_done, buffer_num);
    end
  endtask

  task automatic test_watchdog();
    int n;
    apply_reset();
    set_dly(0);
    send_frame(2, 1'b1, -1);
    wait_frames(1);
    model_flip();
`ifdef LOADER_CTRL_WATCHDOG_EN
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    checks++;
    if (n != TO || timeout_err !== 1'b1 || buffer_num !== m_buf) begin
      errors++;
      $display("FAIL watchdog cycles=%0d err=%0b buf=%0b required=%0d/1/%0b", n, timeout_err, buffer_num, TO, m_buf);
    end
`else
    n = 0;
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL no_watchdog busy=%0b err=%0b required=1/0", busy, timeout_err);
    end
    release_latch();
`endif
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_random_frames();
    test_latch_ignored();
    test_abort();
    test_buttons();
    test_implicit_last();
    test_wrap();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
